// File: rtl/ysyx_041461_pipe_skid_reg.sv
// Two-entry skid register for a valid/ready pipeline stage.
// Both in_ready and out_data come straight from flops, which cuts the timing path in each direction.
module ysyx_041461_pipe_skid_reg #(
  parameter int unsigned DW      = 64,
  parameter logic [63:0] RST_VAL = 64'h0000_0000_3000_0000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             clr_cnt
);

  localparam logic [DW-1:0]    RST_DATA = DW'(RST_VAL);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    main_q, main_d;
  logic [DW-1:0]    skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_q      <= RST_DATA;
      skid_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Flush wins over any transfer in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (in_fire) state_d = BUSY;
      BUSY: begin
        if (in_fire && !out_fire)      state_d = FULL;
        else if (!in_fire && out_fire) state_d = EMPTY;
      end
      FULL:    if (out_fire) state_d = BUSY;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  // Payload is left untouched on flush; it is don't-care once out_valid drops.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (!flush) begin
      case (state_q)
        EMPTY: if (in_fire) main_d = in_data;
        BUSY: begin
          if (in_fire && out_fire) main_d = in_data;
          else if (in_fire)        skid_d = in_data;
        end
        FULL:    if (out_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)                                        cnt_d = '0;
    else if (out_valid_q && !out_ready && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_041461_pipe_skid_reg.sv
// Scoreboard bench for the skid register: a capacity-2 queue model predicts handshakes, data order and stall counts.
// A second instance with a 3-bit stall counter shares all inputs to exercise saturation.
module tb_ysyx_041461_pipe_skid_reg;

  localparam int          DW      = 64;
  localparam logic [63:0] RST_VAL = 64'h0000_0000_3000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          inValid = 1'b0;
  logic [DW-1:0] inData = '0;
  logic          outReady = 1'b0;
  logic          clrCnt = 1'b0;

  logic          inReady, outValid;
  logic [DW-1:0] outData;
  logic [15:0]   stallCnt;
  logic          inReady3, outValid3;
  logic [DW-1:0] outData3;
  logic [2:0]    stallCnt3;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  logic [DW-1:0] sbQueue[$];
  int modelCount = 0;
  int modelCnt16 = 0;
  int modelCnt3  = 0;

  ysyx_041461_pipe_skid_reg #(.DW(DW), .RST_VAL(RST_VAL), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady), .out_valid(outValid), .out_data(outData),
    .out_ready(outReady), .stall_cnt(stallCnt), .clr_cnt(clrCnt)
  );

  ysyx_041461_pipe_skid_reg #(.DW(DW), .RST_VAL(RST_VAL), .CNT_W(3)) dutSat (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(inValid), .in_data(inData),
    .in_ready(inReady3), .out_valid(outValid3), .out_data(outData3),
    .out_ready(outReady), .stall_cnt(stallCnt3), .clr_cnt(clrCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: capacity-2 FIFO plus saturating stall counters, evaluated with the inputs held across the edge.
  task automatic modelEdge();
    int inFire;
    int outFire;
    if (!rst) begin
      sbQueue.delete();
      modelCount = 0;
      modelCnt16 = 0;
      modelCnt3  = 0;
      return;
    end
    inFire  = (inValid && modelCount < 2) ? 1 : 0;
    outFire = (modelCount > 0 && outReady) ? 1 : 0;
    if (clrCnt) begin
      modelCnt16 = 0;
      modelCnt3  = 0;
    end else if (modelCount > 0 && !outReady) begin
      if (modelCnt16 < 65535) modelCnt16++;
      if (modelCnt3 < 7)      modelCnt3++;
    end
    if (flush) begin
      sbQueue.delete();
      modelCount = 0;
    end else begin
      modelCount = modelCount - outFire + inFire;
      if (inFire == 1) sbQueue.push_back(inData);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit v, input logic [DW-1:0] d,
                               input bit o, input bit c);
    rst = r; flush = f; inValid = v; inData = d; outReady = o; clrCnt = c;
    @(posedge clk);
    #1;
    modelEdge();
  endtask

  // Monitor: compares handshake flags and counters every cycle, and pops the scoreboard on each delivered entry.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("out_valid", 64'(outValid), (modelCount > 0) ? 64'd1 : 64'd0);
      checkOutput("in_ready", 64'(inReady), (modelCount < 2) ? 64'd1 : 64'd0);
      checkOutput("stall_cnt", 64'(stallCnt), 64'(modelCnt16));
      checkOutput("stall_cnt_sat", 64'(stallCnt3), 64'(modelCnt3));
      if (outValid === 1'b1) begin
        if (sbQueue.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL out_data: got %0h, expected no entry at %0t", outData, $time);
        end else begin
          checkOutput("out_data", outData, sbQueue[0]);
          if (outReady && !flush && rst) void'(sbQueue.pop_front());
        end
      end
    end
  end

  initial begin
    applyStimulus(0, 0, 0, '0, 0, 0);
    applyStimulus(0, 0, 0, '0, 0, 0);
    checkEn = 1'b1;
    checkOutput("reset_out_data", outData, RST_VAL);
    checkOutput("reset_in_ready", 64'(inReady), 64'd1);

    for (int i = 1; i <= 8; i++) applyStimulus(1, 0, 1, DW'(i), 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);

    applyStimulus(1, 0, 1, 64'hA, 0, 0);
    applyStimulus(1, 0, 1, 64'hB, 0, 0);
    checkOutput("bp_in_ready", 64'(inReady), 64'd0);
    checkOutput("bp_out_data", outData, 64'hA);
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, '0, 0, 0);
    checkOutput("bp_stall", 64'(stallCnt), 64'd4);
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);

    applyStimulus(1, 0, 1, 64'hA, 0, 0);
    applyStimulus(1, 0, 1, 64'hB, 0, 0);
    applyStimulus(1, 1, 1, 64'hC, 0, 0);
    checkOutput("flush_out_valid", 64'(outValid), 64'd0);
    checkOutput("flush_out_data", outData, 64'hA);
    checkOutput("flush_stall", 64'(stallCnt), 64'd6);
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);

    applyStimulus(1, 0, 0, '0, 1, 1);
    applyStimulus(1, 0, 1, 64'h77, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, '0, 0, 0);
    checkOutput("sat_cnt", 64'(stallCnt3), 64'd7);
    checkOutput("wide_cnt", 64'(stallCnt), 64'd10);
    applyStimulus(1, 0, 0, '0, 0, 1);
    checkOutput("clr_cnt", 64'(stallCnt3), 64'd0);
    applyStimulus(1, 0, 0, '0, 1, 0);

    applyStimulus(1, 0, 1, 64'h55, 0, 0);
    applyStimulus(0, 0, 1, 64'h66, 1, 0);
    checkOutput("midrst_out_valid", 64'(outValid), 64'd0);
    checkOutput("midrst_out_data", outData, RST_VAL);
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 127) != 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 9) < 7), {$urandom, $urandom},
                    ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(1, 0, 0, '0, 1, 0);
    applyStimulus(1, 0, 0, '0, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_041461_pipe_skid_reg.md
YSYX_041461_PIPE_SKID_REG -- requirements
Module: ysyx_041461_pipe_skid_reg

Interface
REQ-001 Parameter DW, default 64: payload width in bits, legal range 1..256.
REQ-002 Parameter RST_VAL, default 64'h0000_0000_3000_0000: payload value after reset, truncated to DW bits.
REQ-003 Parameter CNT_W, default 16: stall-counter width in bits, legal range 1..32.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 flush  input  1  kills all held entries at the next edge.
REQ-007 in_valid  input  1  upstream offers in_data.
REQ-008 in_data  input  DW  upstream payload.
REQ-009 in_ready  output  1  stage can accept; driven directly from a flop.
REQ-010 out_valid  output  1  out_data holds a live entry.
REQ-011 out_data  output  DW  head-entry payload, driven directly from a flop.
REQ-012 out_ready  input  1  downstream accepts.
REQ-013 stall_cnt  output  CNT_W  saturating count of back-pressure cycles.
REQ-014 clr_cnt  input  1  clears stall_cnt.

Function
REQ-015 The block SHALL hold up to two entries: main, which drives out_data, and skid.
REQ-016 State SHALL be one of EMPTY (0 entries), BUSY (1 entry) or FULL (2 entries).
REQ-017 in_fire SHALL equal in_valid & in_ready, and out_fire SHALL equal out_valid & out_ready.
REQ-018 out_valid SHALL be 1 in BUSY and FULL, and 0 in EMPTY.
REQ-019 in_ready SHALL be 1 in EMPTY and BUSY, and 0 in FULL.
REQ-020 EMPTY transitions:
- in_fire: main<=in_data, go to BUSY.
- otherwise: stay in EMPTY, main unchanged.
REQ-021 BUSY transitions:
- in_fire & !out_fire: skid<=in_data, go to FULL.
- in_fire & out_fire: main<=in_data, stay in BUSY.
- !in_fire & out_fire: go to EMPTY.
- neither: hold.
REQ-022 FULL transitions: out_fire SHALL set main<=skid and go to BUSY; otherwise hold.
REQ-023 Latency SHALL be one cycle: data accepted at edge N is visible on out_data after edge N when the block was EMPTY, or after BUSY with simultaneous out_fire.
REQ-024 Ordering SHALL be strictly FIFO, with no loss or duplication of any accepted entry.
REQ-025 Throughput SHALL be one transfer per cycle while out_ready=1.
REQ-026 While out_valid=1 & out_ready=0, out_data SHALL stay stable.
REQ-027 flush=1 SHALL force EMPTY at the next edge, overriding in_fire and out_fire in the same cycle.
REQ-028 The in_data presented in a flush cycle SHALL be dropped.
REQ-029 On flush, out_data SHALL retain its last value, since it is don't-care while out_valid=0.
REQ-030 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 & out_ready=0.
REQ-031 stall_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-032 clr_cnt=1 SHALL set stall_cnt to 0 at the next edge, taking priority over increment.
REQ-033 flush SHALL NOT affect stall_cnt.
REQ-034 A flush cycle with back-pressure SHALL still count as a stall cycle.

Reset
REQ-035 At a rising clk edge with rst=0, the block SHALL apply:
- state=EMPTY, out_valid=0, in_ready=1
- out_data=RST_VAL[DW-1:0], skid=0
- stall_cnt=0
REQ-036 Reset SHALL have priority over flush, clr_cnt and all transfers.
REQ-037 Reset SHALL discard any held entry mid-operation.
REQ-038 The first transfer SHALL be accepted at the first edge with rst=1.

Verification
REQ-039 Reset: hold rst=0 for 2 cycles, DW=64 -> out_valid=0, in_ready=1, out_data=64'h30000000, stall_cnt=0.
REQ-040 Streaming: send 0x1..0x8 back-to-back with out_ready=1 -> outputs 0x1..0x8 in order, one per cycle, 1-cycle latency, in_ready stays 1, stall_cnt=0.
REQ-041 Back-pressure: out_ready=0, send 0xA then 0xB -> after 2 edges FULL, in_ready=0, out_data=0xA. Hold 3 more cycles -> stall_cnt=4. Raise out_ready -> 0xA then 0xB delivered, in_ready=1 the cycle after the first out_fire.
REQ-042 Flush in FULL with in_valid=1 and in_data=0xC -> next cycle out_valid=0, in_ready=1. 0xA, 0xB and 0xC are never emitted; stall_cnt is unchanged apart from the flush-cycle increment.
REQ-043 Saturation: CNT_W=3, back-pressure for 10 cycles -> stall_cnt=7. clr_cnt together with a stall -> 0.
REQ-044 Mid-operation reset: BUSY holding 0x55, assert rst=0 with in_valid=1 and out_ready=1 -> next cycle EMPTY, out_data=RST_VAL, and 0x55 is never emitted.
